// File: rtl/codma_bus_arbiter_if.sv
// rtl/codma_bus_arbiter_if.sv - requester and bus signal bundle for codma_bus_arbiter
interface codma_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 8,
  parameter int DATA_W = 32
);
  // read machine
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [SIZE_W-1:0] rd_size_i;
  logic              rd_gnt_o;
  logic              rd_done_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_beat_o;
  // write machine
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [SIZE_W-1:0] wr_size_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_gnt_o;
  logic              wr_done_o;
  // bus master port
  logic              bus_req_o;
  logic              bus_write_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [SIZE_W-1:0] bus_size_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_gnt_i;
  logic              bus_beat_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_done_i;
  // watchdog abort
  logic              err_o;

  // arbiter side: it is the single master of the shared bus
  modport master (
    input  rd_req_i, rd_addr_i, rd_size_i,
    output rd_gnt_o, rd_done_o, rd_data_o, rd_beat_o,
    input  wr_req_i, wr_addr_i, wr_size_i, wr_data_i,
    output wr_gnt_o, wr_done_o,
    output bus_req_o, bus_write_o, bus_addr_o, bus_size_o, bus_wdata_o,
    input  bus_gnt_i, bus_beat_i, bus_rdata_i, bus_done_i,
    output err_o
  );

  // environment side: read/write machines and the bus interface
  modport slave (
    output rd_req_i, rd_addr_i, rd_size_i,
    input  rd_gnt_o, rd_done_o, rd_data_o, rd_beat_o,
    output wr_req_i, wr_addr_i, wr_size_i, wr_data_i,
    input  wr_gnt_o, wr_done_o,
    input  bus_req_o, bus_write_o, bus_addr_o, bus_size_o, bus_wdata_o,
    output bus_gnt_i, bus_beat_i, bus_rdata_i, bus_done_i,
    input  err_o
  );
endinterface

// File: rtl/codma_bus_arbiter.sv
// rtl/codma_bus_arbiter.sv - round-robin owner arbiter for the shared CoDMA bus master port
// Optional watchdog abort enabled by defining CODMA_ARB_TIMEOUT_EN.
module codma_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int SIZE_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk_i,
  input logic                 reset_i,
  codma_bus_arbiter_if.master arb_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // owner encoding: 0 = read machine, 1 = write machine
  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              w_next_owner;
  logic              r_last_owner;
  logic              r_rd_beat;
  logic [DATA_W-1:0] r_rd_data;

  logic w_busy;
  logic w_beat_ok;
  logic w_bus_end;

  assign w_busy = (r_state != S_IDLE);

  // beats only count once the bus has accepted the request
  assign w_beat_ok = arb_if.bus_beat_i &&
                     ((r_state == S_XFER) || ((r_state == S_REQ) && arb_if.bus_gnt_i));

  // normal completion, including grant and done landing in the same REQ cycle
  assign w_bus_end = ((r_state == S_XFER) && arb_if.bus_done_i) ||
                     ((r_state == S_REQ) && arb_if.bus_gnt_i && arb_if.bus_done_i);

`ifdef CODMA_ARB_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        r_err;
  logic        w_wd_abort;

  // abort only when the limit is hit and the bus is not finishing on its own
  assign w_wd_abort = ((r_state == S_REQ) || (r_state == S_XFER)) &&
                      !w_beat_ok && !w_bus_end &&
                      (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  // watchdog: zero outside REQ/XFER so it starts from 0 on REQ entry, restarts on each beat
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wd_cnt <= '0;
    end else if ((r_state != S_REQ) && (r_state != S_XFER)) begin
      r_wd_cnt <= '0;
    end else if (w_beat_ok) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  // error flag is raised in the DONE cycle produced by an abort
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_wd_abort;
    end
  end

  assign arb_if.err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign arb_if.err_o     = 1'b0;
`endif

  // state, owner and round-robin history registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      if (r_state == S_DONE) begin
        r_last_owner <= r_owner;
      end
    end
  end

  // next-state and owner selection
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    case (r_state)
      S_IDLE: begin
        if (arb_if.rd_req_i || arb_if.wr_req_i) begin
          w_next_state = S_REQ;
          if (arb_if.rd_req_i && arb_if.wr_req_i) begin
            w_next_owner = ~r_last_owner;
          end else begin
            w_next_owner = arb_if.wr_req_i;
          end
        end
      end
      S_REQ: begin
        if (arb_if.bus_gnt_i) begin
          w_next_state = arb_if.bus_done_i ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (arb_if.bus_done_i) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
`ifdef CODMA_ARB_TIMEOUT_EN
    if (w_wd_abort) begin
      w_next_state = S_DONE;
    end
`endif
  end

  // read data path: beat strobe and data registered together, one cycle after the bus beat
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_beat <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_beat <= w_beat_ok && !r_owner;
      if (w_beat_ok && !r_owner) begin
        r_rd_data <= arb_if.bus_rdata_i;
      end
    end
  end

  assign arb_if.rd_beat_o = r_rd_beat;
  assign arb_if.rd_data_o = r_rd_data;

  assign arb_if.rd_gnt_o  = w_busy && !r_owner;
  assign arb_if.wr_gnt_o  = w_busy && r_owner;
  assign arb_if.rd_done_o = (r_state == S_DONE) && !r_owner;
  assign arb_if.wr_done_o = (r_state == S_DONE) && r_owner;

  assign arb_if.bus_req_o   = (r_state == S_REQ);
  assign arb_if.bus_write_o = w_busy && r_owner;
  assign arb_if.bus_addr_o  = !w_busy ? '0 : (r_owner ? arb_if.wr_addr_i : arb_if.rd_addr_i);
  assign arb_if.bus_size_o  = !w_busy ? '0 : (r_owner ? arb_if.wr_size_i : arb_if.rd_size_i);
  assign arb_if.bus_wdata_o = (w_busy && r_owner) ? arb_if.wr_data_i : '0;

endmodule

// File: tb/tb_codma_bus_arbiter.sv
// tb/tb_codma_bus_arbiter.sv - directed self-checking bench for codma_bus_arbiter
module tb_codma_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 8;
  localparam int DATA_W = 32;

`ifdef CODMA_ARB_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic clk_i;
  logic reset_i;

  int n_cmp;
  int n_err;
  int rd_done_cnt;
  int wr_done_cnt;
  int both_gnt_cnt;
  int err_cnt;
  int rd_done_mark;
  int wr_done_mark;

  codma_bus_arbiter_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)) arb_bus ();

  codma_bus_arbiter #(
    .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .arb_if (arb_bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // passive monitor counting events between checks
  always @(negedge clk_i) begin
    if (arb_bus.rd_gnt_o && arb_bus.wr_gnt_o) both_gnt_cnt++;
    if (arb_bus.rd_done_o) rd_done_cnt++;
    if (arb_bus.wr_done_o) wr_done_cnt++;
    if (arb_bus.err_o) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rd_done_cnt = 0; wr_done_cnt = 0; both_gnt_cnt = 0; err_cnt = 0;
    reset_i = 1'b1;
    arb_bus.rd_req_i = 0; arb_bus.rd_addr_i = '0; arb_bus.rd_size_i = '0;
    arb_bus.wr_req_i = 0; arb_bus.wr_addr_i = '0; arb_bus.wr_size_i = '0; arb_bus.wr_data_i = '0;
    arb_bus.bus_gnt_i = 0; arb_bus.bus_beat_i = 0; arb_bus.bus_rdata_i = '0; arb_bus.bus_done_i = 0;
    step(); step();
    reset_i = 1'b0;

    // reset state
    check("rst_bus_req", arb_bus.bus_req_o, 0);
    check("rst_rd_gnt", arb_bus.rd_gnt_o, 0);
    check("rst_wr_gnt", arb_bus.wr_gnt_o, 0);
    check("rst_addr", arb_bus.bus_addr_o, 0);
    check("rst_rd_beat", arb_bus.rd_beat_o, 0);
    check("rst_rd_data", arb_bus.rd_data_o, 0);
    check("rst_err", arb_bus.err_o, 0);
    rd_done_cnt = 0; wr_done_cnt = 0; both_gnt_cnt = 0; err_cnt = 0;

    // stray bus strobes in IDLE are ignored
    arb_bus.bus_beat_i = 1; arb_bus.bus_done_i = 1; arb_bus.bus_rdata_i = 32'h5555_AAAA;
    step();
    arb_bus.bus_beat_i = 0; arb_bus.bus_done_i = 0;
    check("idle_stray_beat", arb_bus.rd_beat_o, 0);
    check("idle_stray_req", arb_bus.bus_req_o, 0);
    check("idle_stray_done", rd_done_cnt, 0);

    // single read, 8 beats
    arb_bus.rd_req_i = 1; arb_bus.rd_addr_i = 32'h1000; arb_bus.rd_size_i = 8'd8;
    step();
    check("rd_bus_req", arb_bus.bus_req_o, 1);
    check("rd_bus_write", arb_bus.bus_write_o, 0);
    check("rd_bus_addr", arb_bus.bus_addr_o, 32'h1000);
    check("rd_bus_size", arb_bus.bus_size_o, 8);
    check("rd_gnt", arb_bus.rd_gnt_o, 1);
    arb_bus.bus_gnt_i = 1;
    step();
    arb_bus.bus_gnt_i = 0;
    check("rd_xfer_req_low", arb_bus.bus_req_o, 0);
    for (int i = 0; i < 8; i++) begin
      arb_bus.bus_beat_i = 1; arb_bus.bus_rdata_i = 32'hA000_0000 + 32'(i);
      step();
      check("rd_beat", arb_bus.rd_beat_o, 1);
      check("rd_data", arb_bus.rd_data_o, 32'hA000_0000 + 32'(i));
    end
    arb_bus.bus_beat_i = 0; arb_bus.bus_done_i = 1;
    step();
    arb_bus.bus_done_i = 0;
    check("rd_done_pulse", arb_bus.rd_done_o, 1);
    check("rd_gnt_in_done", arb_bus.rd_gnt_o, 1);
    arb_bus.rd_req_i = 0;
    step();
    check("rd_done_low", arb_bus.rd_done_o, 0);
    check("rd_gnt_idle", arb_bus.rd_gnt_o, 0);
    check("rd_done_once", rd_done_cnt, 1);

    // single write
    arb_bus.wr_req_i = 1; arb_bus.wr_addr_i = 32'h2000; arb_bus.wr_size_i = 8'd4;
    arb_bus.wr_data_i = 32'hDEAD_BEEF;
    step();
    check("wr_bus_write", arb_bus.bus_write_o, 1);
    check("wr_bus_addr", arb_bus.bus_addr_o, 32'h2000);
    check("wr_bus_wdata", arb_bus.bus_wdata_o, 32'hDEAD_BEEF);
    check("wr_gnt", arb_bus.wr_gnt_o, 1);
    check("wr_rd_gnt_low", arb_bus.rd_gnt_o, 0);
    arb_bus.bus_gnt_i = 1;
    step();
    arb_bus.bus_gnt_i = 0;
    for (int i = 0; i < 2; i++) begin
      arb_bus.bus_beat_i = 1; arb_bus.bus_rdata_i = 32'h0BAD_0000 + 32'(i);
      step();
      check("wr_no_rd_beat", arb_bus.rd_beat_o, 0);
    end
    arb_bus.bus_beat_i = 0;
    arb_bus.wr_data_i = 32'h1234_5678;
    #1;
    check("wr_wdata_follow", arb_bus.bus_wdata_o, 32'h1234_5678);
    arb_bus.bus_done_i = 1;
    step();
    arb_bus.bus_done_i = 0;
    check("wr_done_pulse", arb_bus.wr_done_o, 1);
    check("wr_done_rd_beat", arb_bus.rd_beat_o, 0);
    arb_bus.wr_req_i = 0;
    step();
    check("wr_idle_wdata", arb_bus.bus_wdata_o, 0);
    check("wr_idle_write", arb_bus.bus_write_o, 0);

    // both requesting: read, write, read, write
    arb_bus.rd_req_i = 1; arb_bus.rd_addr_i = 32'h3000;
    arb_bus.wr_req_i = 1; arb_bus.wr_addr_i = 32'h4000;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_rd_gnt", arb_bus.rd_gnt_o, (k % 2 == 0) ? 1 : 0);
      check("rr_wr_gnt", arb_bus.wr_gnt_o, (k % 2 == 1) ? 1 : 0);
      check("rr_addr", arb_bus.bus_addr_o, (k % 2 == 0) ? 32'h3000 : 32'h4000);
      arb_bus.bus_gnt_i = 1;
      step();
      arb_bus.bus_gnt_i = 0; arb_bus.bus_done_i = 1;
      step();
      arb_bus.bus_done_i = 0;
      step();
    end
    arb_bus.rd_req_i = 0; arb_bus.wr_req_i = 0;
    step();

    // grant and done in the same REQ cycle
    rd_done_mark = rd_done_cnt;
    arb_bus.rd_req_i = 1; arb_bus.rd_addr_i = 32'h1800;
    step();
    check("same_req", arb_bus.bus_req_o, 1);
    arb_bus.bus_gnt_i = 1; arb_bus.bus_done_i = 1;
    step();
    arb_bus.bus_gnt_i = 0; arb_bus.bus_done_i = 0; arb_bus.rd_req_i = 0;
    check("same_done", arb_bus.rd_done_o, 1);
    step();
    check("same_idle_gnt", arb_bus.rd_gnt_o, 0);
    check("same_idle_req", arb_bus.bus_req_o, 0);
    check("same_done_cnt", rd_done_cnt - rd_done_mark, 1);

    // reset during XFER
    arb_bus.wr_req_i = 1; arb_bus.wr_addr_i = 32'h2400;
    step();
    arb_bus.bus_gnt_i = 1;
    step();
    arb_bus.bus_gnt_i = 0;
    wr_done_mark = wr_done_cnt;
    reset_i = 1;
    step();
    reset_i = 0; arb_bus.wr_req_i = 0;
    check("rstx_wr_gnt", arb_bus.wr_gnt_o, 0);
    check("rstx_wr_done", arb_bus.wr_done_o, 0);
    check("rstx_write", arb_bus.bus_write_o, 0);
    check("rstx_addr", arb_bus.bus_addr_o, 0);
    check("rstx_wdata", arb_bus.bus_wdata_o, 0);
    step();
    check("rstx_no_done", wr_done_cnt - wr_done_mark, 0);
    arb_bus.rd_req_i = 1; arb_bus.rd_addr_i = 32'h5000;
    step();
    check("rstx_new_req", arb_bus.bus_req_o, 1);
    check("rstx_new_addr", arb_bus.bus_addr_o, 32'h5000);
    check("rstx_new_gnt", arb_bus.rd_gnt_o, 1);
    arb_bus.bus_gnt_i = 1; arb_bus.bus_done_i = 1;
    step();
    arb_bus.bus_gnt_i = 0; arb_bus.bus_done_i = 0; arb_bus.rd_req_i = 0;
    check("rstx_new_done", arb_bus.rd_done_o, 1);
    step();

    // stalled write: watchdog abort or indefinite wait
    wr_done_mark = wr_done_cnt;
    arb_bus.wr_req_i = 1; arb_bus.wr_addr_i = 32'h6000;
    step();
    arb_bus.bus_gnt_i = 1;
    step();
    arb_bus.bus_gnt_i = 0; arb_bus.wr_req_i = 0;
    for (int i = 0; i < 14; i++) step();
    check("tmo_err_early", arb_bus.err_o, 0);
    check("tmo_done_early", arb_bus.wr_done_o, 0);
    step();
    check("tmo_err", arb_bus.err_o, TMO_EN);
    check("tmo_wr_done", arb_bus.wr_done_o, TMO_EN);
`ifdef CODMA_ARB_TIMEOUT_EN
    step();
    check("tmo_err_pulse", arb_bus.err_o, 0);
    check("tmo_idle_gnt", arb_bus.wr_gnt_o, 0);
    check("tmo_err_cnt", err_cnt, 1);
`else
    check("tmo_hold_gnt", arb_bus.wr_gnt_o, 1);
    check("tmo_hold_req", arb_bus.bus_req_o, 0);
    check("tmo_err_cnt", err_cnt, 0);
    arb_bus.bus_done_i = 1;
    step();
    arb_bus.bus_done_i = 0;
    check("tmo_late_done", arb_bus.wr_done_o, 1);
    step();
`endif
    check("tmo_done_cnt", wr_done_cnt - wr_done_mark, 1);
    check("never_both_gnt", both_gnt_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
